// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor. The carry chain is cut into STAGES
// chunks of WIDTH/STAGES bits, with optional saturation and Zero/Neg flags.
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ov,
  output logic             Zero,
  output logic             Neg
);

  localparam int CW = WIDTH / STAGES;
  localparam int NM = (STAGES > 1) ? STAGES - 1 : 1;

  // Intermediate stages: full operands travel forward, s_q holds the sum bits resolved so far.
  logic [WIDTH-1:0] a_q   [NM];
  logic [WIDTH-1:0] be_q  [NM];
  logic [WIDTH-1:0] s_q   [NM];
  logic             c_q   [NM];
  logic             sat_q [NM];
  logic             v_q   [NM];

  logic [WIDTH-1:0] res_q;
  logic             out_valid_q;
  logic             cout_q;
  logic             ov_q;
  logic             zero_q;
  logic             neg_q;

  logic [WIDTH-1:0] be_in;
  logic [STAGES-1:0] en;

  assign be_in = sub ? ~B : B;

  // Handshake: a transfer happens on any rising edge where valid && ready on that side.
  // A stage may load when it is empty or when the stage after it loads in the same edge.
  always_comb begin : p_enable
    logic full;
    full            = out_valid_q;
    en              = '0;
    en[STAGES-1]    = !full || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      full  = full && v_q[k];
      en[k] = !full || out_ready;
    end
  end

  assign in_ready = rst_n && en[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0]    a_c;
    logic [CW-1:0]    b_c;
    logic             c_in;
    logic             sat_in;
    logic             v_in;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_new;
    logic [CW:0]      chunk;

    if (k == 0) begin : g_src_in
      assign a_c    = A[CW-1:0];
      assign b_c    = be_in[CW-1:0];
      assign c_in   = sub;
      assign sat_in = sat;
      assign v_in   = in_valid && in_ready;
      assign s_in   = '0;
    end else begin : g_src_reg
      assign a_c    = a_q[k-1][k*CW +: CW];
      assign b_c    = be_q[k-1][k*CW +: CW];
      assign c_in   = c_q[k-1];
      assign sat_in = sat_q[k-1];
      assign v_in   = v_q[k-1];
      assign s_in   = s_q[k-1];
    end

    assign chunk = {1'b0, a_c} + {1'b0, b_c} + {{CW{1'b0}}, c_in};

    always_comb begin
      s_new              = s_in;
      s_new[k*CW +: CW]  = chunk[CW-1:0];
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] a_fwd;
      logic [WIDTH-1:0] be_fwd;

      if (k == 0) begin : g_fwd_in
        assign a_fwd  = A;
        assign be_fwd = be_in;
      end else begin : g_fwd_reg
        assign a_fwd  = a_q[k-1];
        assign be_fwd = be_q[k-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q[k]   <= 1'b0;
          a_q[k]   <= '0;
          be_q[k]  <= '0;
          s_q[k]   <= '0;
          c_q[k]   <= 1'b0;
          sat_q[k] <= 1'b0;
        end else if (en[k]) begin
          v_q[k]   <= v_in;
          a_q[k]   <= a_fwd;
          be_q[k]  <= be_fwd;
          s_q[k]   <= s_new;
          c_q[k]   <= chunk[CW];
          sat_q[k] <= sat_in;
        end
      end
    end else begin : g_last
      logic             c_msb;
      logic             ov_d;
      logic             sat_hit;
      logic [WIDTH-1:0] res_d;

      // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
      assign c_msb   = chunk[CW-1] ^ a_c[CW-1] ^ b_c[CW-1];
      assign ov_d    = c_msb ^ chunk[CW];
      assign sat_hit = (SAT_EN != 0) && sat_in && ov_d;

      always_comb begin
        res_d = s_new;
        if (sat_hit) begin
          res_d = a_c[CW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          res_q       <= '0;
          cout_q      <= 1'b0;
          ov_q        <= 1'b0;
          zero_q      <= 1'b0;
          neg_q       <= 1'b0;
        end else if (en[k]) begin
          out_valid_q <= v_in;
          res_q       <= res_d;
          cout_q      <= chunk[CW];
          ov_q        <= ov_d;
          zero_q      <= (res_d == '0);
          neg_q       <= res_d[WIDTH-1];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign S         = res_q;
  assign Cout      = cout_q;
  assign Ov        = ov_q;
  assign Zero      = zero_q;
  assign Neg       = neg_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe (WIDTH=8, STAGES=2, SAT_EN=1): directed vectors, stall/flow
// behaviour, randomized traffic against an arithmetic reference model, and mid-stream reset.
module tb_addsub_pipe;

  localparam int W = 8;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         sub_i;
  logic         sat_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ov;
  logic         zero;
  logic         neg;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .STAGES(2), .SAT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_i), .B(b_i), .sub(sub_i), .sat(sat_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(s), .Cout(cout), .Ov(ov), .Zero(zero), .Neg(neg)
  );

  // Result tuple: {S, Cout, Ov, Zero, Neg}
  typedef logic [W+3:0] res_t;

  res_t exp_q[$];
  res_t pend;
  res_t samp_res;
  res_t prev_res;
  res_t held;
  logic samp_in_ready;
  logic samp_out_valid;
  logic prev_stall;
  int   checks = 0;
  int   errors = 0;

  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic op_sub, logic op_sat);
    int sa, sb, r, o;
    logic c, v;
    logic [W-1:0] so;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = op_sub ? sa - sb : sa + sb;
    c  = op_sub ? (int'(a) >= int'(b)) : ((int'(a) + int'(b)) > ((1 << W) - 1));
    v  = (r > MAXV) || (r < MINV);
    o  = (op_sat && v) ? ((r > 0) ? MAXV : MINV) : r;
    so = o[W-1:0];
    return {so, c, v, (so == '0), so[W-1]};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, score outputs and accepts, return at posedge+1.
  task automatic tick(output bit acc);
    @(negedge clk);
    samp_in_ready  = in_ready;
    samp_out_valid = out_valid;
    samp_res       = {s, cout, ov, zero, neg};
    if (prev_stall) chk("stall_hold", 32'({samp_out_valid, samp_res}), 32'({1'b1, prev_res}));
    prev_stall = rst_n && out_valid && !out_ready;
    prev_res   = samp_res;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'(samp_out_valid), 32'd0);
      else chk("result", 32'(samp_res), 32'(exp_q.pop_front()));
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic op_sub, logic op_sat,
                      res_t exp, output int waited);
    bit acc;
    a_i = a; b_i = b; sub_i = op_sub; sat_i = op_sat;
    in_valid = 1'b1;
    pend = exp;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 50) begin
      tick(acc);
      waited++;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) tick(acc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           acc;
    bit           have_item;
    bit           first;
    int           w;
    int           idx;
    logic [W-1:0] ia [4];
    logic [W-1:0] ib [4];
    logic [W-1:0] corner [4];

    corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_i = '0; b_i = '0; sub_i = 1'b0; sat_i = 1'b0;
    pend = '0; prev_stall = 1'b0; prev_res = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({in_ready, out_valid, s, cout, ov, zero, neg}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(acc);
    chk("ready_after_reset", 32'(samp_in_ready), 32'd1);

    // Latency: visible two cycles after presentation, nothing one cycle earlier
    send(8'd100, 8'd27, 1'b0, 1'b0, {8'h7F, 4'b0000}, w);
    in_valid = 1'b0;
    tick(acc);
    chk("latency_stage0", 32'(samp_out_valid), 32'd0);
    tick(acc);
    chk("latency_out", 32'(samp_out_valid), 32'd1);

    // Directed vectors, back-to-back
    send(8'd100, 8'd28, 1'b0, 1'b0, {8'h80, 4'b0101}, w);
    send(8'd100, 8'd28, 1'b0, 1'b1, {8'h7F, 4'b0100}, w);
    send(8'd5,   8'd7,  1'b1, 1'b0, {8'hFE, 4'b0001}, w);
    send(8'd3,   8'd3,  1'b1, 1'b0, {8'h00, 4'b1010}, w);
    send(8'h80,  8'd1,  1'b1, 1'b1, {8'h80, 4'b1101}, w);
    send(8'h80,  8'd1,  1'b1, 1'b0, {8'h7F, 4'b1100}, w);
    idle(4);
    chk("directed_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure: four adds offered while out_ready is low
    for (int i = 0; i < 4; i++) begin
      ia[i] = 8'($urandom);
      ib[i] = 8'($urandom);
    end
    out_ready = 1'b0;
    idx = 0;
    held = '0;
    for (int c = 0; c < 4; c++) begin
      a_i = ia[idx]; b_i = ib[idx]; sub_i = 1'b0; sat_i = 1'b0;
      pend = model(ia[idx], ib[idx], 1'b0, 1'b0);
      in_valid = 1'b1;
      tick(acc);
      if (acc) idx++;
      if (c == 2) held = samp_res;
    end
    chk("stall_accepted", 32'(idx), 32'd2);
    chk("stall_in_ready", 32'(samp_in_ready), 32'd0);
    chk("stall_out_valid", 32'(samp_out_valid), 32'd1);
    chk("stall_held", 32'(samp_res), 32'(held));
    chk("stall_value", 32'(samp_res), 32'(model(ia[0], ib[0], 1'b0, 1'b0)));

    // Release: first remaining item must be accepted on the retiring edge
    out_ready = 1'b1;
    first = 1'b1;
    while (idx < 4) begin
      send(ia[idx], ib[idx], 1'b0, 1'b0, model(ia[idx], ib[idx], 1'b0, 1'b0), w);
      if (first) chk("no_stall_cycle", 32'(w), 32'd1);
      first = 1'b0;
      idx++;
    end
    idle(4);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Randomized traffic with random gaps and back-pressure
    have_item = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!have_item) begin
        a_i   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
        b_i   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
        sub_i = 1'($urandom_range(0, 1));
        sat_i = 1'($urandom_range(0, 1));
        pend  = model(a_i, b_i, sub_i, sat_i);
        have_item = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (acc) have_item = 1'b0;
    end
    out_ready = 1'b1;
    idle(4);
    chk("random_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two transactions in flight
    send(8'd20, 8'd30, 1'b0, 1'b0, model(8'd20, 8'd30, 1'b0, 1'b0), w);
    send(8'd40, 8'd9,  1'b1, 1'b0, model(8'd40, 8'd9, 1'b1, 1'b0), w);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("reset_async_out", 32'({out_valid, s}), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(acc);
    chk("ready_after_midreset", 32'(samp_in_ready), 32'd1);
    idle(4);
    send(8'd127, 8'd1, 1'b0, 1'b1, {8'h7F, 4'b0100}, w);
    idle(4);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor.
- Generalises the 5-bit ripple adder with overflow to WIDTH bits. The carry chain is split across STAGES register stages.
- Adds per-transaction add/sub and saturate modes, Zero/Neg flags, and a valid/ready handshake on both sides.
- Sits between operand sources (register file, switch inputs) and result consumers (display, accumulator) in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be ≥ 2 and WIDTH % STAGES == 0.
- STAGES, 2, number of pipeline stages. Each stage resolves CW = WIDTH/STAGES bits of the sum.
- SAT_EN, 1, 1 = saturation logic present; 0 = the sat input is ignored.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transaction present
- in_ready  output  1  block accepts the transaction this cycle
- A  input  WIDTH  operand A, signed
- B  input  WIDTH  operand B, signed
- sub  input  1  0 = A+B, 1 = A−B
- sat  input  1  1 = clamp on signed overflow
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- S  output  WIDTH  result
- Cout  output  1  carry out of the MSB (for sub: 1 = no borrow)
- Ov  output  1  signed overflow of the unclamped sum
- Zero  output  1  S == 0, evaluated after saturation
- Neg  output  1  S[WIDTH-1], evaluated after saturation

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits, data registers and outputs go to 0.
  - in_ready is forced to 0 while rst_n is low.
  - Transactions in flight are discarded, not completed.
- Acceptance: a transaction is accepted when in_valid && in_ready at a clk edge. A, B, sub and sat are captured at that edge.
- Arithmetic:
  - Effective operand Be = sub ? ~B : B; carry-in = sub.
  - Full-width sum = A + Be + sub.
  - Cout = carry out of bit WIDTH-1.
  - Ov = carry into bit WIDTH-1 XOR Cout.
- Pipeline data flow:
  - Stage k (0..STAGES-1) adds operand bits [(k+1)*CW-1 : k*CW] using the carry registered by stage k-1.
  - Stage 0 uses the carry-in.
  - Upper operand chunks and the sub/sat flags travel forward in skew registers.
  - The final stage also registers the carry into the MSB, for Ov.
- Saturation: when SAT_EN && sat && Ov, S = A[WIDTH-1] ? 1 followed by WIDTH-1 zeros (most negative) : 0 followed by WIDTH-1 ones (most positive). Cout and Ov still report the unclamped sum. When not saturating, S = raw sum.
- Flow control:
  - Each stage k holds valid bit v[k].
  - en[last] = !v[last] || out_ready; en[k] = !v[k] || en[k+1].
  - in_ready = en[0] (when rst_n is high).
  - A stage loads only when its en is 1; v[k] loads v[k-1] (v[0] loads in_valid && in_ready).
  - Bubbles collapse; all stages advancing together is legal.
- Latency and throughput:
  - Latency is exactly STAGES cycles from the accept edge to out_valid high, with out_ready held high.
  - Throughput is 1 result/cycle.
- Output stability: while out_valid && !out_ready, S, Cout, Ov, Zero and Neg hold stable. out_valid stays high until a handshake occurs.
- Full condition: when all stages are valid and out_ready is 0, in_ready = 0 in the same cycle (combinational).
- Simultaneous events: on a cycle where out_ready is 1 and a new input arrives with a full pipe, the output retires and the input is accepted on the same edge. No stall cycle is inserted.
- Outputs are registered except in_ready. Flags are computed from the final-stage register, so no combinational path from A/B to the outputs.

Test Plan (WIDTH=8, STAGES=2, SAT_EN=1, out_ready=1 unless stated):
- A=100, B=27, sub=0, sat=0 -> after 2 cycles: S=127 (0x7F), Cout=0, Ov=0, Zero=0, Neg=0.
- A=100, B=28, sub=0, sat=0 -> S=0x80, Ov=1, Neg=1. The same operands with sat=1 -> S=0x7F, Ov=1, Neg=0.
- A=5, B=7, sub=1 -> S=0xFE, Cout=0, Ov=0, Neg=1. Then A=3, B=3, sub=1 -> S=0x00, Cout=1, Zero=1.
- A=0x80, B=1, sub=1, sat=1 -> Ov=1, S=0x80, Neg=1. The same operands with sat=0 -> S=0x7F, Ov=1.
- Back-to-back stream of 4 adds with out_ready=0 for 4 cycles -> only 2 accepted, then in_ready=0 and the S value is held. Release out_ready -> the remaining results appear in order, one per cycle, with no loss or duplication.
- Reset mid-stream (rst_n low 1 cycle with 2 transactions in flight) -> out_valid=0 and S=0 immediately, no stale result after release, and in_ready=1 on the first cycle after rst_n is high.
